// File: rtl/rect_drop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_drop_pkg
//  Description : Shared types and constants for the rectangle drop sequencer.
//                Holds the sequencer state encoding, the Q8.8 fractional
//                width and the default floor position derived from the
//                visible screen height and the rectangle height.
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_drop_pkg;

   typedef enum logic [1:0] {
      FOLLOW = 2'd0,
      FALL   = 2'd1,
      REST   = 2'd2
   } drop_state_t;

   localparam int FRAC_BITS      = 8;
   localparam int VISIBLE_HEIGHT = 600;
   localparam int RECT_HEIGHT    = 64;
   // Lowest ypos at which the rectangle is still fully visible.
   localparam int DEFAULT_FLOOR  = VISIBLE_HEIGHT - RECT_HEIGHT;

endpackage
`default_nettype wire

// File: rtl/rect_drop_sequencer_rising_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : rising_edge_det
//  Description : Single-cycle pulse on a 0->1 transition of a level input
//                that is already in the clk domain.
//  Ports       : clk   - clock
//                rst   - asynchronous active-low reset (clears history)
//                d     - level input
//                pulse - high for one cycle when d rises
//  Revision    : 1.0 - initial release
// ============================================================================
module rising_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic pulse
);

   logic r_d_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_d_q <= 1'b0;
      end else begin
         r_d_q <= d;
      end
   end

   assign pulse = d & ~r_d_q;

endmodule
`default_nettype wire

// File: rtl/rect_drop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rect_drop_sequencer
//  Description : Drives the rectangle position through three phases:
//                follow the mouse, fall under gravity with damped bounces,
//                and rest on the floor. Physics advances once per frame on
//                the vsync rising edge.
//  Ports       : clk        - pixel clock
//                rst        - asynchronous active-low reset
//                vsync      - frame sync, active high, clk domain
//                mouse_left - left button level
//                mouse_xpos - mouse x in pixels (12 bit)
//                mouse_ypos - mouse y in pixels (12 bit)
//                xpos       - rectangle x, registered
//                ypos       - rectangle y (integer part), registered
//                busy       - high while falling
//                bounce_cnt - bounces since the last drop
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_drop_sequencer
   import rect_drop_pkg::*;
#(
   parameter int FLOOR       = DEFAULT_FLOOR,
   parameter int GRAVITY     = 64,
   parameter int DAMP_SHIFT  = 1,
   parameter int MIN_VEL     = 256,
   parameter int MAX_BOUNCES = 8,
   parameter int VMAX        = 16383
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        busy,
   output logic [3:0]  bounce_cnt
);

   localparam logic signed [20:0] c_floor_fp    = 21'(FLOOR << FRAC_BITS);
   localparam logic        [11:0] c_floor_px    = 12'(FLOOR);
   localparam logic signed [16:0] c_vmax        = 17'(VMAX);
   localparam logic signed [16:0] c_vneg        = 17'(-VMAX);
   localparam logic signed [16:0] c_gravity     = 17'(GRAVITY);
   localparam logic        [15:0] c_min_vel     = 16'(MIN_VEL);
   localparam logic        [4:0]  c_max_bounces = 5'(MAX_BOUNCES);

   drop_state_t        r_state;
   logic [11:0]        r_xpos;
   logic [19:0]        r_pos_fp;      // unsigned Q12.8
   logic signed [15:0] r_vel;         // signed Q8.8
   logic [3:0]         r_bounce_cnt;
   logic               r_busy;

   logic               w_tick;
   logic               w_click;
   logic signed [16:0] w_vsum;
   logic signed [15:0] w_va;
   logic signed [20:0] w_pn;
   logic [15:0]        w_abs_va;
   logic [15:0]        w_vd;
   logic [4:0]         w_bc_inc;
   logic [3:0]         w_bc_sat;
   logic               w_bounce;
   logic               w_ceiling;
   logic               w_stop;
   logic [11:0]        w_mouse_y_clamped;

   rising_edge_det u_vsync_edge (
      .clk   (clk),
      .rst   (rst),
      .d     (vsync),
      .pulse (w_tick)
   );

   rising_edge_det u_click_edge (
      .clk   (clk),
      .rst   (rst),
      .d     (mouse_left),
      .pulse (w_click)
   );

   // One physics step, evaluated every cycle but only committed on a tick.
   always_comb begin
      w_vsum = {r_vel[15], r_vel} + c_gravity;
      if (w_vsum > c_vmax) begin
         w_va = c_vmax[15:0];
      end else if (w_vsum < c_vneg) begin
         w_va = c_vneg[15:0];
      end else begin
         w_va = w_vsum[15:0];
      end

      // 21-bit signed so an upward overshoot past row 0 shows as negative.
      w_pn = $signed({1'b0, r_pos_fp}) + $signed({{5{w_va[15]}}, w_va});

      w_abs_va = w_va[15] ? 16'(-w_va) : 16'(w_va);
      w_vd     = w_abs_va - (w_abs_va >> DAMP_SHIFT);

      w_bounce  = (w_pn >= c_floor_fp);
      w_ceiling = w_pn[20];

      // Unsaturated count decides termination; the visible count saturates.
      w_bc_inc = {1'b0, r_bounce_cnt} + 5'd1;
      w_bc_sat = (r_bounce_cnt == 4'hF) ? 4'hF : w_bc_inc[3:0];
      w_stop   = (w_vd < c_min_vel) || (w_bc_inc >= c_max_bounces);

      w_mouse_y_clamped = (mouse_ypos > c_floor_px) ? c_floor_px : mouse_ypos;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= FOLLOW;
         r_xpos       <= 12'd0;
         r_pos_fp     <= 20'd0;
         r_vel        <= 16'sd0;
         r_bounce_cnt <= 4'd0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            FOLLOW: begin
               if (w_click) begin
                  // Position freezes at the last tracked value; a tick in
                  // this same cycle does not start physics.
                  r_state      <= FALL;
                  r_vel        <= 16'sd0;
                  r_bounce_cnt <= 4'd0;
                  r_busy       <= 1'b1;
               end else begin
                  r_xpos   <= mouse_xpos;
                  r_pos_fp <= {w_mouse_y_clamped, 8'h00};
               end
            end

            FALL: begin
               if (w_tick) begin
                  if (w_bounce) begin
                     r_pos_fp     <= c_floor_fp[19:0];
                     r_bounce_cnt <= w_bc_sat;
                     if (w_stop) begin
                        r_vel   <= 16'sd0;
                        r_state <= REST;
                        r_busy  <= 1'b0;
                     end else begin
                        r_vel <= -$signed(w_vd);
                     end
                  end else if (w_ceiling) begin
                     r_pos_fp <= 20'd0;
                     r_vel    <= 16'sd0;
                  end else begin
                     r_pos_fp <= w_pn[19:0];
                     r_vel    <= w_va;
                  end
               end
            end

            REST: begin
               if (w_click) begin
                  r_state <= FOLLOW;
               end
            end

            default: begin
               r_state <= FOLLOW;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign xpos       = r_xpos;
   assign ypos       = r_pos_fp[19:8];
   assign busy       = r_busy;
   assign bounce_cnt = r_bounce_cnt;

endmodule
`default_nettype wire

// File: doc/rect_drop_sequencer.md
Name: rect_drop_sequencer

Overview:
- Sequences the on-screen rectangle position between three phases: follow the mouse, fall under gravity with damped bounces, and rest on the floor.
- Physics updates are scheduled once per video frame on the vsync rising edge, not on a free-running divider.
- Sits between the mouse controller (position and left button) and the rectangle drawer (xpos/ypos).

Parameters:
FLOOR, 536, maximum ypos in pixels (visible height 600 minus rectangle height 64)
GRAVITY, 64, velocity increment per frame, signed Q8.8 px/frame (64 = 0.25 px/frame^2)
DAMP_SHIFT, 1, bounce damping: new |v| = |v| - (|v| >> DAMP_SHIFT)
MIN_VEL, 256, post-bounce |v| below this (Q8.8, 1 px/frame) ends motion
MAX_BOUNCES, 8, bounce count that forces REST
VMAX, 16383, velocity saturation magnitude (Q8.8)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
vsync  in  1  frame sync from VGA timing, same clk domain, active high
mouse_left  in  1  left button level, clk domain
mouse_xpos  in  12  mouse x, pixels
mouse_ypos  in  12  mouse y, pixels
xpos  out  12  rectangle x, registered
ypos  out  12  rectangle y, integer part of position, registered
busy  out  1  high in FALL
bounce_cnt  out  4  bounces since last drop

Behaviour:
- Reset: async assert clears to state FOLLOW, xpos=0, ypos=0, pos_fp=0, vel=0, bounce_cnt=0, busy=0, edge-detect history=0. Reset mid-fall abandons motion immediately.
- Edge detect: click = mouse_left & ~mouse_left_q; tick = vsync & ~vsync_q. A held button produces one click only.
- Position is held as pos_fp: unsigned Q12.8, 20 bits. ypos = pos_fp[19:8]. Velocity vel: signed 16-bit Q8.8.
- FOLLOW state:
  - Each cycle: xpos <= mouse_xpos; pos_fp <= min(mouse_ypos, FLOOR) << 8. Latency is 1 cycle.
  - On click: go to FALL with vel=0, bounce_cnt=0, xpos frozen. A tick in the same cycle is ignored; the first physics step happens on the next tick.
- FALL state (busy=1). xpos is held. Nothing changes except on a tick, which does the following:
  - va = sat(vel + GRAVITY, ±VMAX).
  - pn = signed(pos_fp) + sign-extended va, computed 21-bit signed.
  - If pn >= FLOOR<<8 (bounce):
    - pos_fp = FLOOR<<8.
    - vd = |va| - (|va| >> DAMP_SHIFT); vel = -vd.
    - bounce_cnt = bounce_cnt + 1, saturating at 15.
    - If vd < MIN_VEL or bounce_cnt+1 >= MAX_BOUNCES: go to REST with vel=0.
  - Else if pn < 0 (ceiling): pos_fp = 0, vel = 0.
  - Else: pos_fp = pn, vel = va.
  - Clicks in FALL are ignored.
- REST state: position held, busy=0. On click go to FOLLOW; ypos tracks the mouse from the next cycle. Ticks are ignored.
- All outputs come from flops; no combinational path from inputs to outputs.

Decomposition:
- Package rect_drop_pkg holds:
  - typedef enum logic [1:0] {FOLLOW, FALL, REST} drop_state_t
  - Q8.8 constant FRAC_BITS=8
  - a default-FLOOR localparam derived from VISIBLE_HEIGHT=600 and RECT_HEIGHT=64
- One sub-module, rising_edge_det (clk, rst, d, pulse), instanced twice: once for vsync, once for mouse_left.

Test Plan:
- Reset then mouse at (300,700) -> after 1 cycle xpos=300, ypos=536 (clamped); busy=0.
- Mouse (100,100), click, then 3 ticks -> ypos 100, 100, 101 (pos 100.25, 100.75, 101.5); vel 64, 128, 192; xpos stays 100 while mouse moves to 400.
- Drop from y=0 and run ticks until the first floor contact -> ypos=536, bounce_cnt=1, vel negative with |vel| = |va|/2; subsequent ticks move ypos upward.
- Continue the drop until termination -> state REST, busy=0, ypos=536, within MAX_BOUNCES; extra ticks leave ypos unchanged; click returns to FOLLOW with mouse tracking.
- Click and tick in the same cycle in FOLLOW -> FALL entered, ypos unchanged until the next tick; button held 1000 cycles -> exactly one click; click in FALL -> no effect.
- Assert rst low mid-fall between clock edges -> outputs go to zero immediately (async); after release, state FOLLOW, bounce_cnt=0.
